// File: rtl/hpi_txn_sequencer.sv
// HPI transaction sequencer: turns a valid/ready request into timed
// CS/RD/WR strobes toward hpi_io_intf and returns a one-cycle response.
module hpi_txn_sequencer #(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  output logic [1:0]  sw_address,
  output logic [15:0] sw_data_out,
  input  logic [15:0] sw_data_in,
  output logic        sw_r,
  output logic        sw_w,
  output logic        sw_cs,
  input  logic        otg_int_in,
  output logic        irq
);

  localparam int MAX_SH = (SETUP_CYC > HOLD_CYC) ?
                          SETUP_CYC : HOLD_CYC;
  localparam int MAXC   = (STROBE_CYC > MAX_SH) ?
                          STROBE_CYC : MAX_SH;
  localparam int CW     = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] SET_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STB_LD = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] HLD_LD = CW'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RESP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          accept;
  logic          wr_q;
  logic          irq_meta;
  logic          last_strobe;

  assign req_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign last_strobe = (state == STROBE) && (cnt == '0);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_n = SETUP;
          cnt_n   = SET_LD;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_n = STROBE;
          cnt_n   = STB_LD;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      STROBE: begin
        if (cnt == '0) begin
          state_n = HOLD;
          cnt_n   = HLD_LD;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_n = RESP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Strobes are decoded from the next state so they line up with
  // the state register while still coming straight out of flops.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_q        <= 1'b0;
      sw_address  <= '0;
      sw_data_out <= '0;
      sw_cs       <= 1'b1;
      sw_r        <= 1'b1;
      sw_w        <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      if (accept) begin
        wr_q        <= req_write;
        sw_address  <= req_addr;
        sw_data_out <= req_write ? req_wdata : 16'h0000;
      end
      sw_cs     <= !(state_n inside {SETUP, STROBE, HOLD});
      sw_w      <= !((state_n == STROBE) && wr_q);
      sw_r      <= !((state_n == STROBE) && !wr_q);
      rsp_valid <= (state_n == RESP);
      if (last_strobe && !wr_q)
        rsp_rdata <= sw_data_in;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      irq_meta <= 1'b0;
      irq      <= 1'b0;
    end else begin
      irq_meta <= otg_int_in;
      irq      <= irq_meta;
    end
  end

endmodule

// File: tb/tb_hpi_txn_sequencer.sv
// Bench for hpi_txn_sequencer: vector table with a response
// scoreboard plus hand sequences for back-to-back, reset and irq.
module tb_hpi_txn_sequencer;

  logic        Clk;
  logic        Reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        busy;
  logic [1:0]  sw_address;
  logic [15:0] sw_data_out;
  logic [15:0] sw_data_in;
  logic        sw_r;
  logic        sw_w;
  logic        sw_cs;
  logic        otg_int_in;
  logic        irq;

  logic [15:0] rd_val;
  logic [15:0] sb[$];
  int          tests;
  int          fails;

  hpi_txn_sequencer dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .busy       (busy),
    .sw_address (sw_address),
    .sw_data_out(sw_data_out),
    .sw_data_in (sw_data_in),
    .sw_r       (sw_r),
    .sw_w       (sw_w),
    .sw_cs      (sw_cs),
    .otg_int_in (otg_int_in),
    .irq        (irq)
  );

  // Device model drives read data only while RD is low.
  assign sw_data_in = sw_r ? 16'h0000 : rd_val;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (!Reset) begin
      chk("rw_overlap", {31'd0, !sw_r && !sw_w}, 32'd0);
      chk("strobe_no_cs",
          {31'd0, sw_cs && (!sw_r || !sw_w)}, 32'd0);
      if (rsp_valid) begin
        if (sb.size() == 0)
          chk("rsp_unexpected", 32'd1, 32'd0);
        else
          chk("rsp_rdata", {16'd0, rsp_rdata},
              {16'd0, sb.pop_front()});
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 40) begin
      @(negedge Clk);
      n++;
    end
    chk("ready_timeout", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic run_txn(input logic        w,
                         input logic [1:0]  a,
                         input logic [15:0] d,
                         input logic [15:0] rv,
                         input logic [15:0] exp,
                         input bit          tog);
    @(negedge Clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    rd_val    = rv;
    wait_ready();
    sb.push_back(exp);
    @(posedge Clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge Clk);
      chk("tl_cs", {31'd0, sw_cs}, {31'd0, k > 8});
      chk("tl_w", {31'd0, sw_w},
          {31'd0, !(w && k >= 3 && k <= 6)});
      chk("tl_r", {31'd0, sw_r},
          {31'd0, !(!w && k >= 3 && k <= 6)});
      chk("tl_addr", {30'd0, sw_address}, {30'd0, a});
      chk("tl_data", {16'd0, sw_data_out},
          {16'd0, w ? d : 16'h0000});
      chk("tl_rsp", {31'd0, rsp_valid}, {31'd0, k == 9});
      chk("tl_ready", {31'd0, req_ready}, 32'd0);
      if (tog) begin
        req_valid = (k < 9) ? k[0] : 1'b0;
        req_write = 1'($urandom);
        req_addr  = 2'($urandom);
        req_wdata = 16'($urandom);
      end
    end
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  a;
    logic [15:0] d;
    logic [15:0] rv;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    tests      = 0;
    fails      = 0;
    Reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 2'd0;
    req_wdata  = 16'h0000;
    rd_val     = 16'h0000;
    otg_int_in = 1'b0;

    vecs[0] = '{1'b1, 2'd2, 16'h1234, 16'h0000, 16'h0000};
    vecs[1] = '{1'b0, 2'd0, 16'h0000, 16'hBEEF, 16'hBEEF};
    vecs[2] = '{1'b1, 2'd1, 16'hABCD, 16'h0000, 16'hBEEF};
    vecs[3] = '{1'b0, 2'd3, 16'h0000, 16'h5A5A, 16'h5A5A};
    vecs[4] = '{1'b0, 2'd1, 16'h0000, 16'h0000, 16'h0000};
    vecs[5] = '{1'b1, 2'd0, 16'hFFFF, 16'h0000, 16'h0000};
    vecs[6] = '{1'b0, 2'd2, 16'h0000, 16'hFFFF, 16'hFFFF};

    repeat (2) @(negedge Clk);
    chk("rst_cs", {31'd0, sw_cs}, 32'd1);
    chk("rst_r", {31'd0, sw_r}, 32'd1);
    chk("rst_w", {31'd0, sw_w}, 32'd1);
    chk("rst_addr", {30'd0, sw_address}, 32'd0);
    chk("rst_data", {16'd0, sw_data_out}, 32'd0);
    chk("rst_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", {16'd0, rsp_rdata}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    Reset = 1'b0;

    foreach (vecs[i])
      run_txn(vecs[i].w, vecs[i].a, vecs[i].d,
              vecs[i].rv, vecs[i].exp, 1'b0);

    // Back-to-back reads with req_valid held high
    @(negedge Clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 2'd0;
    rd_val    = 16'h1111;
    wait_ready();
    sb.push_back(16'h1111);
    sb.push_back(16'h2222);
    @(posedge Clk);
    for (int k = 1; k <= 11; k++) begin
      @(negedge Clk);
      if (k == 7) rd_val = 16'h2222;
      if (k <= 10)
        chk("b2b_ready", {31'd0, req_ready},
            {31'd0, k == 10});
      if (k == 9 || k == 10)
        chk("b2b_gap_cs", {31'd0, sw_cs}, 32'd1);
      if (k == 11) begin
        chk("b2b_second_cs", {31'd0, sw_cs}, 32'd0);
        req_valid = 1'b0;
      end
    end
    for (int n = 0; n < 20 && busy; n++) @(negedge Clk);
    chk("b2b_idle", {31'd0, busy}, 32'd0);

    // Request lines wiggle during the transaction
    run_txn(1'b1, 2'd1, 16'h0F0F, 16'h0000, 16'h2222, 1'b1);
    @(negedge Clk);
    chk("tog_no_accept", {31'd0, busy}, 32'd0);
    chk("tog_sb_empty", sb.size(), 32'd0);

    // Reset in the middle of a write strobe
    @(negedge Clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 2'd3;
    req_wdata = 16'hA5A5;
    wait_ready();
    @(posedge Clk);
    #1 req_valid = 1'b0;
    repeat (4) @(negedge Clk);
    chk("mid_w_low", {31'd0, sw_w}, 32'd0);
    chk("mid_cs_low", {31'd0, sw_cs}, 32'd0);
    #2 Reset = 1'b1;
    #1;
    chk("arst_w", {31'd0, sw_w}, 32'd1);
    chk("arst_cs", {31'd0, sw_cs}, 32'd1);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    chk("arst_ready", {31'd0, req_ready}, 32'd1);
    for (int k = 0; k < 12; k++) begin
      @(negedge Clk);
      if (k == 11)
        chk("arst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    chk("arst_rdata", {16'd0, rsp_rdata}, 32'd0);

    // OTG interrupt synchroniser
    @(negedge Clk);
    otg_int_in = 1'b1;
    @(posedge Clk);
    #1 chk("irq_edge1", {31'd0, irq}, 32'd0);
    @(posedge Clk);
    #1 chk("irq_edge2", {31'd0, irq}, 32'd1);
    @(negedge Clk);
    otg_int_in = 1'b0;
    @(posedge Clk);
    #1 chk("irq_fall1", {31'd0, irq}, 32'd1);
    @(posedge Clk);
    #1 chk("irq_fall2", {31'd0, irq}, 32'd0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
